// File: rtl/trap_pkg.sv
// Shared trap definitions for the interrupt arbiter.
// Holds the FSM state type, the source index constants (bit positions in
// the {mei, msi, mti} vectors) and the mcause code of each source.
// Helpers pick the highest-priority eligible source and map a source
// index to its cause code.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2
  } irq_state_e;

  localparam logic [1:0] SRC_MTI = 2'd0;
  localparam logic [1:0] SRC_MSI = 2'd1;
  localparam logic [1:0] SRC_MEI = 2'd2;

  localparam logic [31:0] CAUSE_MEI = {1'b1, 31'd11};
  localparam logic [31:0] CAUSE_MSI = {1'b1, 31'd3};
  localparam logic [31:0] CAUSE_MTI = {1'b1, 31'd7};

  // Fixed priority MEI > MSI > MTI; caller guarantees elig != 0.
  function automatic logic [1:0] pick_winner(input logic [2:0] elig);
    if (elig[SRC_MEI])      return SRC_MEI;
    else if (elig[SRC_MSI]) return SRC_MSI;
    else                    return SRC_MTI;
  endfunction

  function automatic logic [31:0] cause_of(input logic [1:0] idx);
    case (idx)
      SRC_MEI: return CAUSE_MEI;
      SRC_MSI: return CAUSE_MSI;
      default: return CAUSE_MTI;
    endcase
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Trap handshake between the interrupt arbiter and the exception unit.
//   irq_req    : arbiter requests a trap
//   irq_cause  : mcause value of the granted source
//   in_handler : an interrupt handler is running
//   trap_ack   : one-cycle pulse, core has begun the trap
//   XB_bubble  : XB stage is empty (an ack is ignored while set)
//   mret       : one-cycle pulse, handler has returned
// master = arbiter side, slave = exception unit side.
interface irq_arbiter_if;

  logic        irq_req;
  logic [31:0] irq_cause;
  logic        in_handler;
  logic        trap_ack;
  logic        XB_bubble;
  logic        mret;

  modport master (
    output irq_req, irq_cause, in_handler,
    input  trap_ack, XB_bubble, mret
  );

  modport slave (
    input  irq_req, irq_cause, in_handler,
    output trap_ack, XB_bubble, mret
  );

endinterface

// File: rtl/irq_edge_latch.sv
// Rising-edge detector and pending latch for one interrupt line.
//   clk, resetb : clock, synchronous active-low reset
//   src         : level interrupt line
//   clr         : clear request (accepted ack granting this source)
//   pend        : latched pending bit
// A set and a clear in the same cycle leave the bit set.
module irq_edge_latch (
  input  logic clk,
  input  logic resetb,
  input  logic src,
  input  logic clr,
  output logic pend
);

  logic armed_q, armed_d;
  logic line_q, line_d;
  logic pend_q, pend_d;
  logic rise;

  // armed_q masks the first cycle after reset so that a line already high
  // at release is only sampled, not treated as an edge.
  always_comb begin
    armed_d = 1'b1;
    line_d  = src;
    rise    = armed_q & src & ~line_q;
    pend_d  = pend_q;
    if (clr)  pend_d = 1'b0;
    if (rise) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      armed_q <= 1'b0;
      line_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      line_q  <= line_d;
      pend_q  <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter.
// Latches rising edges of the external, software and timer interrupt
// lines, picks the highest-priority eligible source (MEI > MSI > MTI) and
// holds a trap request with a stable cause until the core accepts it, then
// blocks further requests until mret.
//   clk, resetb  : clock, synchronous active-low reset
//   src_meip/msip/mtip : level interrupt lines
//   en           : {meie, msie, mtie} from mie
//   gie          : mstatus.MIE
//   trap         : trap handshake (irq_req, irq_cause, in_handler,
//                  trap_ack, XB_bubble, mret)
//   pending      : latched {meip, msip, mtip} for mip reads
//   wait_cycles  : saturating count of cycles the current request waited
module irq_arbiter
  import trap_pkg::*;
#(
  parameter int unsigned WAIT_W = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              src_meip,
  input  logic              src_msip,
  input  logic              src_mtip,
  input  logic [2:0]        en,
  input  logic              gie,
  irq_arbiter_if.master     trap,
  output logic [2:0]        pending,
  output logic [WAIT_W-1:0] wait_cycles
);

  irq_state_e        state_q, state_d;
  logic [31:0]       cause_q, cause_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [2:0]        clr_vec;
  logic [2:0]        eligible;
  logic              accept;

  irq_edge_latch u_mei (
    .clk   (clk),
    .resetb(resetb),
    .src   (src_meip),
    .clr   (clr_vec[SRC_MEI]),
    .pend  (pending[SRC_MEI])
  );

  irq_edge_latch u_msi (
    .clk   (clk),
    .resetb(resetb),
    .src   (src_msip),
    .clr   (clr_vec[SRC_MSI]),
    .pend  (pending[SRC_MSI])
  );

  irq_edge_latch u_mti (
    .clk   (clk),
    .resetb(resetb),
    .src   (src_mtip),
    .clr   (clr_vec[SRC_MTI]),
    .pend  (pending[SRC_MTI])
  );

  assign eligible = pending & en;
  assign accept   = trap.trap_ack & ~trap.XB_bubble;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    gnt_d   = gnt_q;
    wait_d  = wait_q;
    clr_vec = '0;
    case (state_q)
      ST_IDLE: begin
        if (gie && (eligible != '0)) begin
          state_d = ST_REQ;
          gnt_d   = pick_winner(eligible);
          cause_d = cause_of(pick_winner(eligible));
          wait_d  = '0;
        end
      end
      ST_REQ: begin
        if (wait_q != '1) wait_d = wait_q + 1'b1;
        // Ack is checked first so it wins over a simultaneous withdraw.
        if (accept) begin
          state_d = ST_HANDLER;
          clr_vec = 3'b001 << gnt_q;
        end else if (!gie || !en[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_HANDLER: begin
        if (trap.mret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      gnt_q   <= SRC_MTI;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      gnt_q   <= gnt_d;
      wait_q  <= wait_d;
    end
  end

  assign trap.irq_req    = (state_q == ST_REQ);
  assign trap.in_handler = (state_q == ST_HANDLER);
  assign trap.irq_cause  = cause_q;
  assign wait_cycles     = wait_q;

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned WMAX   = (1 << WAIT_W) - 1;
  localparam int unsigned VW     = 37 + WAIT_W;

  logic              clk = 1'b0;
  logic              resetb;
  logic              src_meip, src_msip, src_mtip;
  logic [2:0]        en;
  logic              gie;
  logic [2:0]        pending;
  logic [WAIT_W-1:0] wait_cycles;

  int checks   = 0;
  int failures = 0;

  irq_arbiter_if bus ();

  irq_arbiter #(.WAIT_W(WAIT_W)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .src_meip   (src_meip),
    .src_msip   (src_msip),
    .src_mtip   (src_mtip),
    .en         (en),
    .gie        (gie),
    .trap       (bus),
    .pending    (pending),
    .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  // Behavioural reference: index 0 = MTI, 1 = MSI, 2 = MEI.
  logic [31:0] cause_tab [3] = '{32'h8000_0007, 32'h8000_0003, 32'h8000_000B};
  bit [2:0]    m_prev, m_pend;
  bit          m_armed, m_active, m_handler;
  int          m_gnt, m_wait;
  logic [31:0] m_cause = '0;

  task automatic model_step();
    bit [2:0] srcv, clr, elig, rise;
    bit       ack;
    srcv = {src_meip, src_msip, src_mtip};
    if (!resetb) begin
      m_prev = '0; m_pend = '0; m_armed = 0; m_active = 0; m_handler = 0;
      m_gnt = 0; m_wait = 0; m_cause = '0;
    end else begin
      ack  = bus.trap_ack && !bus.XB_bubble;
      clr  = '0;
      elig = m_pend & en;
      if (m_handler) begin
        if (bus.mret) m_handler = 0;
      end else if (m_active) begin
        m_wait = (m_wait >= int'(WMAX)) ? int'(WMAX) : m_wait + 1;
        if (ack) begin
          m_active = 0; m_handler = 1; clr[m_gnt] = 1'b1;
        end else if (!gie || !en[m_gnt]) begin
          m_active = 0;
        end
      end else if (gie && elig != 0) begin
        for (int i = 0; i < 3; i++) if (elig[i]) m_gnt = i;  // highest index wins
        m_cause  = cause_tab[m_gnt];
        m_active = 1;
        m_wait   = 0;
      end
      rise    = m_armed ? (srcv & ~m_prev) : 3'b000;
      m_pend  = (m_pend & ~clr) | rise;
      m_prev  = srcv;
      m_armed = 1;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_active, m_cause, m_pend, m_handler, WAIT_W'(m_wait)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.irq_req, bus.irq_cause, pending, bus.in_handler, wait_cycles};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    src_meip = 0; src_msip = 0; src_mtip = 0;
    bus.trap_ack = 0; bus.XB_bubble = 0; bus.mret = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    resetb = 0;
    tick(); tick();
    resetb = 1;
    tick();
  endtask

  task automatic test_reset();
    quiet_inputs();
    en = 3'b111; gie = 1; resetb = 0;
    tick(); tick(); tick();
    checks++;
    if (dut_vec() !== '0)
      begin failures++; $display("FAIL reset_outputs: got %h want 0", dut_vec()); end
    checks++;
    if (dut_vec() !== exp_vec())
      begin failures++; $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec()); end
    resetb = 1;
    tick();
  endtask

  task automatic test_mti_only();
    do_reset();
    en = 3'b001; gie = 1;
    src_mtip = 1;
    tick();
    checks++;
    if (bus.irq_req !== 1'b0 || pending !== 3'b001)
      begin failures++; $display("FAIL mti_cycle1: irq_req=%0b pending=%b want 0/001", bus.irq_req, pending); end
    tick();
    checks++;
    if (bus.irq_req !== 1'b1 || bus.irq_cause !== 32'h8000_0007)
      begin failures++; $display("FAIL mti_cycle2: irq_req=%0b cause=%h want 1/80000007", bus.irq_req, bus.irq_cause); end
    bus.trap_ack = 1;
    tick();
    bus.trap_ack = 0;
    checks++;
    if (pending[0] !== 1'b0 || bus.in_handler !== 1'b1)
      begin failures++; $display("FAIL mti_ack: pending0=%0b in_handler=%0b want 0/1", pending[0], bus.in_handler); end
    bus.mret = 1;
    tick();
    bus.mret = 0;
    checks++;
    if (dut_vec() !== exp_vec())
      begin failures++; $display("FAIL mti_mret: got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] want [3] = '{32'h8000_000B, 32'h8000_0003, 32'h8000_0007};
    do_reset();
    en = 3'b111; gie = 1;
    src_meip = 1; src_msip = 1; src_mtip = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 6 && bus.irq_req !== 1'b1; n++) tick();
      checks++;
      if (bus.irq_req !== 1'b1 || bus.irq_cause !== want[k])
        begin failures++; $display("FAIL simul_grant%0d: irq_req=%0b cause=%h want 1/%h", k, bus.irq_req, bus.irq_cause, want[k]); end
      bus.trap_ack = 1; tick(); bus.trap_ack = 0;
      bus.mret = 1; tick(); bus.mret = 0;
    end
    checks++;
    if (pending !== 3'b000 || dut_vec() !== exp_vec())
      begin failures++; $display("FAIL simul_done: got %h want %h", dut_vec(), exp_vec()); end
    quiet_inputs();
    tick();
  endtask

  task automatic test_bubble_ack();
    do_reset();
    en = 3'b111; gie = 1;
    src_msip = 1;
    tick(); tick();
    src_meip = 1;  // higher priority arrives while MSI is being requested
    bus.trap_ack = 1; bus.XB_bubble = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus.irq_req !== 1'b1 || bus.irq_cause !== 32'h8000_0003 || wait_cycles !== WAIT_W'(i))
        begin failures++; $display("FAIL bubble_hold%0d: req=%0b cause=%h wait=%0d want 1/80000003/%0d", i, bus.irq_req, bus.irq_cause, wait_cycles, i); end
    end
    bus.XB_bubble = 0;
    tick();
    bus.trap_ack = 0;
    checks++;
    if (bus.in_handler !== 1'b1 || pending !== 3'b100 || wait_cycles !== WAIT_W'(4))
      begin failures++; $display("FAIL bubble_accept: in_handler=%0b pending=%b wait=%0d want 1/100/4", bus.in_handler, pending, wait_cycles); end
    tick();
    checks++;
    if (wait_cycles !== WAIT_W'(4) || dut_vec() !== exp_vec())
      begin failures++; $display("FAIL bubble_hold_wait: got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_withdraw();
    do_reset();
    en = 3'b111; gie = 1;
    src_meip = 1;
    tick(); tick();
    gie = 0;
    tick();
    checks++;
    if (bus.irq_req !== 1'b0 || pending[2] !== 1'b1)
      begin failures++; $display("FAIL withdraw_gie: req=%0b pend2=%0b want 0/1", bus.irq_req, pending[2]); end
    gie = 1;
    tick();
    checks++;
    if (bus.irq_req !== 1'b1 || bus.irq_cause !== 32'h8000_000B)
      begin failures++; $display("FAIL withdraw_reissue: req=%0b cause=%h want 1/8000000B", bus.irq_req, bus.irq_cause); end
    en = 3'b011;
    tick();
    checks++;
    if (bus.irq_req !== 1'b0 || pending !== 3'b100)
      begin failures++; $display("FAIL withdraw_en: req=%0b pending=%b want 0/100", bus.irq_req, pending); end
    en = 3'b111;
    tick();
    gie = 0; bus.trap_ack = 1;  // withdraw and accepted ack together
    tick();
    gie = 1; bus.trap_ack = 0;
    checks++;
    if (bus.in_handler !== 1'b1 || pending[2] !== 1'b0)
      begin failures++; $display("FAIL withdraw_ack_wins: in_handler=%0b pend2=%0b want 1/0", bus.in_handler, pending[2]); end
    bus.mret = 1; tick(); bus.mret = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 3'b001; gie = 1;
    src_mtip = 1;
    tick(); tick();
    src_mtip = 0;
    tick();
    src_mtip = 1; bus.trap_ack = 1;  // new edge in the same cycle as the clear
    tick();
    bus.trap_ack = 0;
    checks++;
    if (bus.in_handler !== 1'b1 || pending[0] !== 1'b1)
      begin failures++; $display("FAIL set_wins: in_handler=%0b pend0=%0b want 1/1", bus.in_handler, pending[0]); end
    bus.mret = 1; tick(); bus.mret = 0;
    tick();
    checks++;
    if (bus.irq_req !== 1'b1 || bus.irq_cause !== 32'h8000_0007)
      begin failures++; $display("FAIL back_to_back_req: req=%0b cause=%h want 1/80000007", bus.irq_req, bus.irq_cause); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    en = 3'b001; gie = 1;
    src_mtip = 1;
    tick(); tick();
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (bus.irq_req !== 1'b1 || wait_cycles !== WAIT_W'(WMAX))
      begin failures++; $display("FAIL wait_saturate: req=%0b wait=%0d want 1/%0d", bus.irq_req, wait_cycles, WMAX); end
    bus.trap_ack = 1; tick(); bus.trap_ack = 0;
    resetb = 0;
    tick();
    checks++;
    if (dut_vec() !== '0)
      begin failures++; $display("FAIL reset_in_handler: got %h want 0", dut_vec()); end
    resetb = 1;
    tick(); tick(); tick();
    checks++;
    if (pending !== 3'b000 || bus.irq_req !== 1'b0)
      begin failures++; $display("FAIL held_line_no_pend: pending=%b req=%0b want 000/0", pending, bus.irq_req); end
    src_mtip = 0; tick();
    src_mtip = 1; tick(); tick();
    checks++;
    if (bus.irq_req !== 1'b1 || dut_vec() !== exp_vec())
      begin failures++; $display("FAIL retoggle_req: got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    en = 3'b111; gie = 1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(7) == 0) src_meip = ~src_meip;
      if ($urandom_range(7) == 0) src_msip = ~src_msip;
      if ($urandom_range(7) == 0) src_mtip = ~src_mtip;
      if ($urandom_range(15) == 0) en = 3'($urandom);
      gie          = ($urandom_range(9) != 0);
      bus.trap_ack = ($urandom_range(3) == 0);
      bus.XB_bubble = ($urandom_range(2) == 0);
      bus.mret     = ($urandom_range(3) == 0);
      resetb       = ($urandom_range(199) != 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), exp_vec());
        end
      end
    end
    resetb = 1;
    quiet_inputs();
    tick();
  endtask

  initial begin
    resetb = 0; en = '0; gie = 0;
    quiet_inputs();
    test_reset();
    test_mti_only();
    test_simultaneous();
    test_bubble_ack();
    test_withdraw();
    test_back_to_back();
    test_saturation_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter WAIT_W, default 8, SHALL set the width of the request-wait counter.
REQ-002 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 resetb  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 src_meip, src_msip, src_mtip  input  1 each  SHALL be the level interrupt lines (external, software, timer).
REQ-005 en  input  3  SHALL be the per-source enables {meie, msie, mtie}, from the mie CSR.
REQ-006 gie  input  1  SHALL be the global enable (mstatus.MIE).
REQ-007 XB_bubble  input  1  SHALL mark the XB stage as empty.
REQ-008 trap_ack  input  1  SHALL be a one-cycle pulse: the core has begun the trap.
REQ-009 mret  input  1  SHALL be a one-cycle pulse: the handler has returned.
REQ-010 irq_req  output  1  SHALL request a trap from the exception handling unit.
REQ-011 irq_cause  output  32  SHALL carry the mcause value of the granted source.
REQ-012 pending  output  3  SHALL show the latched pending bits {meip, msip, mtip} for mip reads.
REQ-013 in_handler  output  1  SHALL be high while an interrupt handler runs.
REQ-014 wait_cycles  output  WAIT_W  SHALL count the cycles the current request has waited, saturating.

Function
REQ-015 Each source SHALL set its pending bit on a 0->1 edge, detected against a registered copy of the line.
REQ-016 A pending bit SHALL clear only on an accepted ack that grants that source.
REQ-017 If a set and a clear hit the same bit in one cycle, the set SHALL win.
REQ-018 Priority among eligible sources (pending & en) SHALL be MEI > MSI > MTI.
REQ-019 Cause codes SHALL be {1,31'd11} for MEI, {1,31'd3} for MSI and {1,31'd7} for MTI.
REQ-020 The FSM SHALL have three states: IDLE, REQ and HANDLER.
REQ-021 IDLE -> REQ SHALL occur when gie=1 and any source is eligible; the winner's cause is registered on that edge.
REQ-022 irq_req SHALL be 1 exactly while in REQ, so request latency from the source edge is 2 cycles.
REQ-023 irq_cause SHALL stay stable throughout REQ, even if a higher-priority source arrives.
REQ-024 In REQ, an accepted ack (trap_ack=1 with XB_bubble=0) SHALL move to HANDLER and clear the granted pending bit.
REQ-025 A trap_ack with XB_bubble=1 SHALL be ignored.
REQ-026 In REQ, gie=0 or en[granted]=0 without an accepted ack SHALL withdraw the request to IDLE; pending is kept.
REQ-027 If withdraw and accepted ack occur in the same cycle, the ack SHALL win.
REQ-028 In HANDLER, in_handler SHALL be 1 and no new request SHALL be made (no nesting).
REQ-029 mret SHALL move HANDLER -> IDLE; mret in any other state SHALL be ignored.
REQ-030 wait_cycles SHALL clear on entry to REQ, increment each REQ cycle, and saturate at all-ones.
REQ-031 wait_cycles SHALL hold its value outside REQ.

Reset
REQ-032 On resetb=0 the block SHALL enter IDLE with pending=0, registered source copies=0, irq_req=0, irq_cause=0, in_handler=0 and wait_cycles=0.
REQ-033 A reset mid-REQ or mid-HANDLER SHALL abandon the request; lines held high at reset release SHALL not pend until they toggle.

Structure
REQ-034 The cause codes, state encoding and source index constants SHALL live in the shared package trap_pkg.
REQ-035 Per-source edge detection and pending latching SHALL be one sub-module, irq_edge_latch, instantiated three times.

Verification
REQ-036 MTI only: en=3'b001, gie=1, src_mtip rises at cycle 0 -> irq_req=1 at cycle 2 with irq_cause=0x80000007; after ack, pending[0]=0 and in_handler=1.
REQ-037 Simultaneous edges: all three sources rise together, en=3'b111 -> cause 0x8000000B first; after mret, 0x80000003; after the next mret, 0x80000007.
REQ-038 Bubble ack: trap_ack with XB_bubble=1 -> state stays REQ and wait_cycles keeps counting; a later ack with XB_bubble=0 -> HANDLER.
REQ-039 Withdraw: gie drops in REQ -> IDLE with pending kept; gie returns -> request reissued with the same cause.
REQ-040 Saturation and reset: WAIT_W=4, no ack for 20 cycles -> wait_cycles=15; resetb=0 in HANDLER -> all outputs 0 the next cycle.
